// File: rtl/core_pkg.sv
// Shared RV32I core definitions: memory access size encodings, memory-stage state
// encoding and the access legality check.
package core_pkg;

  localparam logic [2:0] MEM_BYTE  = 3'b000;
  localparam logic [2:0] MEM_HALF  = 3'b001;
  localparam logic [2:0] MEM_WORD  = 3'b010;
  localparam logic [2:0] MEM_UBYTE = 3'b100;
  localparam logic [2:0] MEM_UHALF = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mau_state_e;

  // Unsigned sizes exist only for loads; halves need even and words need 4-byte alignment.
  function automatic logic mem_legal(input logic is_store, input logic [2:0] func3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (func3)
      MEM_BYTE:  ok = 1'b1;
      MEM_HALF:  ok = ~addr_lo[0];
      MEM_WORD:  ok = (addr_lo == 2'b00);
      MEM_UBYTE: ok = ~is_store;
      MEM_UHALF: ok = ~is_store & ~addr_lo[0];
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/grant/response data-memory port. master = access unit, slave = memory.
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit_store_lane_gen.sv
// Store byte-strobe and lane-replicated write data from the low address bits and size.
module store_lane_gen
  import core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_data
);

  always_comb begin
    wstrb     = '0;
    lane_data = wdata;
    case (func3)
      MEM_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        wstrb     = 4'b0011 << addr_lo;
        lane_data = {2{wdata[15:0]}};
      end
      MEM_WORD: wstrb = '1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: one load/store per transaction onto the data-memory port,
// load data returned right-aligned and size-masked, illegal accesses faulted locally.
module mem_access_unit
  import core_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_is_load,
  input  logic                      ex_is_store,
  input  logic [31:0]               ex_addr,
  input  logic [2:0]                ex_func3,
  input  logic [31:0]               ex_wdata,
  mem_access_unit_if.master         dm,
  output logic                      wb_valid,
  output logic [31:0]               wb_data,
  output logic [2:0]                wb_func3,
  output logic                      wb_fault,
  output logic                      stall
);

  mau_state_e  state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        is_store_q, is_store_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wbv_q, wbv_d, fault_q, fault_d;
  logic [31:0] wbd_q, wbd_d;
  logic [2:0]  f3_q, f3_d;

  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic [31:0] rshift;
  logic [31:0] load_aligned;
  logic        legal;

  store_lane_gen u_lane (
    .addr_lo   (ex_addr[1:0]),
    .func3     (ex_func3),
    .wdata     (ex_wdata),
    .wstrb     (lane_strb),
    .lane_data (lane_data)
  );

  // A malformed op type (neither or both of load/store) faults like a bad size.
  assign legal = (ex_is_load ^ ex_is_store) & mem_legal(ex_is_store, ex_func3, ex_addr[1:0]);

  assign rshift = dm.dm_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    case (f3_q[1:0])
      2'b00:   load_aligned = {24'd0, rshift[7:0]};
      2'b01:   load_aligned = {16'd0, rshift[15:0]};
      default: load_aligned = rshift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_lo_d  = addr_lo_q;
    is_store_d = is_store_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wbv_d      = wbv_q;
    fault_d    = fault_q;
    wbd_d      = wbd_q;
    f3_d       = f3_q;
    ex_ready   = (state_q == IDLE);
    stall      = (state_q == REQ) || (state_q == RESP) || ((state_q == IDLE) && ex_valid);

    case (state_q)
      IDLE: if (ex_valid) begin
        addr_lo_d  = ex_addr[1:0];
        is_store_d = ex_is_store;
        f3_d       = ex_func3;
        if (legal) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = ex_is_store;
          addr_d  = {ex_addr[31:2], 2'b00};
          wstrb_d = ex_is_store ? lane_strb : 4'b0000;
          wdata_d = ex_is_store ? lane_data : 32'd0;
        end else begin
          state_d = DONE;
          wbv_d   = 1'b1;
          fault_d = 1'b1;
          wbd_d   = '0;
        end
      end
      REQ: if (dm.dm_gnt) begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        wstrb_d = '0;
        if (is_store_q) begin
          state_d = DONE;
          wbv_d   = 1'b1;
          fault_d = 1'b0;
          wbd_d   = '0;
        end else begin
          state_d = RESP;
        end
      end
      RESP: if (dm.dm_rvalid) begin
        state_d = DONE;
        wbv_d   = 1'b1;
        fault_d = 1'b0;
        wbd_d   = load_aligned;
      end
      DONE: begin
        state_d = IDLE;
        wbv_d   = 1'b0;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_lo_q  <= '0;
      is_store_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wbv_q      <= 1'b0;
      fault_q    <= 1'b0;
      wbd_q      <= '0;
      f3_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      is_store_q <= is_store_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wbv_q      <= wbv_d;
      fault_q    <= fault_d;
      wbd_q      <= wbd_d;
      f3_q       <= f3_d;
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wstrb = wstrb_q;
  assign dm.dm_wdata = wdata_q;
  assign wb_valid    = wbv_q;
  assign wb_data     = wbd_q;
  assign wb_func3    = f3_q;
  assign wb_fault    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; completions are checked against a scoreboard queue.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  func3;
    logic        fault;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [2:0]  ex_func3 = '0;
  logic [31:0] ex_wdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [2:0]  wb_func3;
  logic        wb_fault;
  logic        stall;

  int tests = 0;
  int fails = 0;
  int wb_count = 0;
  int req_count = 0;
  logic req_prev = 1'b0;
  wb_exp_t sb[$];

  mem_access_unit_if dm_bus ();

  mem_access_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_addr     (ex_addr),
    .ex_func3    (ex_func3),
    .ex_wdata    (ex_wdata),
    .dm          (dm_bus),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_func3    (wb_func3),
    .wb_fault    (wb_fault),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and request-edge counter.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_bus.dm_req && !req_prev) req_count++;
      req_prev = dm_bus.dm_req;
      if (wb_valid) begin
        wb_count++;
        if (sb.size() == 0) begin
          chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        end else begin
          wb_exp_t e;
          e = sb.pop_front();
          chk("sb_wb_data", wb_data, e.data);
          chk("sb_wb_func3", {29'd0, wb_func3}, {29'd0, e.func3});
          chk("sb_wb_fault", {31'd0, wb_fault}, {31'd0, e.fault});
        end
      end
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] f3, input logic flt);
    wb_exp_t e;
    e.data = d; e.func3 = f3; e.fault = flt;
    sb.push_back(e);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
  task automatic issue(input string tag, input logic st, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
    ex_valid = 1'b1; ex_is_store = st; ex_is_load = ~st;
    ex_addr = a; ex_func3 = f3; ex_wdata = wd;
    #1;
    chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
    chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
    step();
    ex_valid = 1'b0;
  endtask

  int wb0, rq0;

  initial begin
    dm_bus.dm_gnt = 1'b0; dm_bus.dm_rvalid = 1'b0; dm_bus.dm_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", {31'd0, dm_bus.dm_req}, 32'd0);
    chk("rst_wstrb", {28'd0, dm_bus.dm_wstrb}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1 chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();

    // SB with immediate grant
    issue("sb", 1'b1, 32'h0000_1003, 3'b000, 32'h1234_56AB);
    push(32'd0, 3'b000, 1'b0);
    chk("sb_req", {31'd0, dm_bus.dm_req}, 32'd1);
    chk("sb_we", {31'd0, dm_bus.dm_we}, 32'd1);
    chk("sb_addr", dm_bus.dm_addr, 32'h0000_1000);
    chk("sb_wstrb", {28'd0, dm_bus.dm_wstrb}, 32'h8);
    chk("sb_wdata", dm_bus.dm_wdata, 32'hABAB_ABAB);
    dm_bus.dm_gnt = 1'b1;
    step();
    dm_bus.dm_gnt = 1'b0;
    chk("sb_wb_t2", {31'd0, wb_valid}, 32'd1);
    chk("sb_stall_done", {31'd0, stall}, 32'd0);
    step();
    chk("sb_wb_drop", {31'd0, wb_valid}, 32'd0);

    // LH, rdata two cycles after grant
    wb0 = wb_count;
    issue("lh", 1'b0, 32'h0000_2002, 3'b001, 32'd0);
    push(32'h0000_8001, 3'b001, 1'b0);
    chk("lh_we", {31'd0, dm_bus.dm_we}, 32'd0);
    chk("lh_wstrb", {28'd0, dm_bus.dm_wstrb}, 32'd0);
    chk("lh_addr", dm_bus.dm_addr, 32'h0000_2000);
    dm_bus.dm_gnt = 1'b1;
    step();
    dm_bus.dm_gnt = 1'b0;
    chk("lh_req_resp", {31'd0, dm_bus.dm_req}, 32'd0);
    chk("lh_stall_resp1", {31'd0, stall}, 32'd1);
    step();
    chk("lh_stall_resp2", {31'd0, stall}, 32'd1);
    dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h8001_1234;
    step();
    dm_bus.dm_rvalid = 1'b0;
    chk("lh_wb", {31'd0, wb_valid}, 32'd1);
    chk("lh_stall_done", {31'd0, stall}, 32'd0);
    step(); step();
    chk("lh_single_pulse", wb_count - wb0, 32'd1);

    // Faults: misaligned LW, misaligned SH, reserved load size
    rq0 = req_count;
    issue("lw_mis", 1'b0, 32'h0000_1001, 3'b010, 32'd0);
    push(32'd0, 3'b010, 1'b1);
    chk("lw_mis_wb", {31'd0, wb_valid}, 32'd1);
    chk("lw_mis_req", {31'd0, dm_bus.dm_req}, 32'd0);
    step();
    issue("sh_mis", 1'b1, 32'h0000_3003, 3'b001, 32'hFFFF_FFFF);
    push(32'd0, 3'b001, 1'b1);
    chk("sh_mis_wb", {31'd0, wb_valid}, 32'd1);
    step();
    issue("ld_f3", 1'b0, 32'h0000_4000, 3'b011, 32'd0);
    push(32'd0, 3'b011, 1'b1);
    chk("ld_f3_wb", {31'd0, wb_valid}, 32'd1);
    step();
    chk("fault_no_req", req_count - rq0, 32'd0);

    // SW with grant withheld three cycles
    issue("sw", 1'b1, 32'h0000_3000, 3'b010, 32'hDEAD_BEEF);
    push(32'd0, 3'b010, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("sw_hold_req", {31'd0, dm_bus.dm_req}, 32'd1);
      chk("sw_hold_addr", dm_bus.dm_addr, 32'h0000_3000);
      chk("sw_hold_wdata", dm_bus.dm_wdata, 32'hDEAD_BEEF);
      chk("sw_hold_wstrb", {28'd0, dm_bus.dm_wstrb}, 32'hF);
      chk("sw_hold_nowb", {31'd0, wb_valid}, 32'd0);
      if (i == 3) dm_bus.dm_gnt = 1'b1;
      step();
    end
    dm_bus.dm_gnt = 1'b0;
    chk("sw_wb", {31'd0, wb_valid}, 32'd1);
    step();

    // LBU interrupted by reset in RESP, late rvalid afterwards
    issue("lbu", 1'b0, 32'h0000_5002, 3'b100, 32'd0);
    dm_bus.dm_gnt = 1'b1;
    step();
    dm_bus.dm_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dm_bus.dm_req}, 32'd0);
    chk("mid_rst_addr", dm_bus.dm_addr, 32'd0);
    chk("mid_rst_func3", {29'd0, wb_func3}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    step();
    rst_n = 1'b1;
    dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'hFFFF_FFFF;
    step();
    dm_bus.dm_rvalid = 1'b0;
    chk("late_rvalid_nowb", {31'd0, wb_valid}, 32'd0);
    chk("late_rvalid_idle", {31'd0, ex_ready}, 32'd1);
    issue("lb", 1'b0, 32'h0000_5001, 3'b000, 32'd0);
    push(32'h0000_00FF, 3'b000, 1'b0);
    dm_bus.dm_gnt = 1'b1;
    step();
    dm_bus.dm_gnt = 1'b0;
    dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h0000_FF00;
    step();
    dm_bus.dm_rvalid = 1'b0;
    chk("lb_wb", {31'd0, wb_valid}, 32'd1);
    step();

    // Back-to-back SW then LW with ex_valid held high
    rq0 = req_count;
    ex_valid = 1'b1; ex_is_store = 1'b1; ex_is_load = 1'b0;
    ex_addr = 32'h0000_6000; ex_func3 = 3'b010; ex_wdata = 32'h1122_3344;
    push(32'd0, 3'b010, 1'b0);
    step();
    ex_is_store = 1'b0; ex_is_load = 1'b1; ex_addr = 32'h0000_6004;
    push(32'hCAFE_F00D, 3'b010, 1'b0);
    #1 chk("b2b_busy", {31'd0, ex_ready}, 32'd0);
    dm_bus.dm_gnt = 1'b1;
    step();
    dm_bus.dm_gnt = 1'b0;
    chk("b2b_wb1", {31'd0, wb_valid}, 32'd1);
    chk("b2b_not_ready_done", {31'd0, ex_ready}, 32'd0);
    step();
    chk("b2b_ready_after", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 1'b0;
    chk("b2b_lw_addr", dm_bus.dm_addr, 32'h0000_6004);
    chk("b2b_lw_we", {31'd0, dm_bus.dm_we}, 32'd0);
    dm_bus.dm_gnt = 1'b1;
    step();
    dm_bus.dm_gnt = 1'b0;
    dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'hCAFE_F00D;
    step();
    dm_bus.dm_rvalid = 1'b0;
    chk("b2b_wb2", {31'd0, wb_valid}, 32'd1);
    step(); step();
    chk("b2b_req_count", req_count - rq0, 32'd2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
